// File: rtl/display_scan_pwm_pkg.sv
// Shared definitions for the LED matrix row scanner: state codes, width helper and polarity helper.
package display_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    // Minimum of 1 so that degenerate parameters still give a legal vector width.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Pin level of an inactive line for the given polarity setting.
    function automatic logic inactive_level(input int active_low);
        return (active_low != 0);
    endfunction

endpackage

// File: rtl/display_scan_timer.sv
// Slot timer for the row scanner: counts blank and drive cycles per row and steps the row index.
module display_scan_timer
    import display_pkg::*;
#(
    parameter int ROWS      = 16,
    parameter int DWELL     = 64,
    parameter int BLANK_CYC = 2,
    parameter int RW        = clog2(ROWS),
    parameter int TW        = clog2((DWELL > BLANK_CYC) ? DWELL : BLANK_CYC)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_run,
    output logic [RW-1:0] o_row_idx,
    output logic [RW-1:0] o_row_nxt,
    output logic [TW-1:0] o_t_nxt,
    output logic          o_drive_nxt,
    output logic          o_frame_wrap
);

    logic [RW-1:0] row_q, row_d;
    logic [TW-1:0] t_q, t_d;
    logic          drive_q, drive_d;
    logic          wrap_d;

    always_comb begin
        row_d   = row_q;
        t_d     = t_q + 1'b1;
        drive_d = drive_q;
        wrap_d  = 1'b0;
        if (!i_run) begin
            // Held at the start of a frame so the next run begins at row 0, blank, t=0.
            row_d   = '0;
            t_d     = '0;
            drive_d = 1'b0;
        end else if (!drive_q) begin
            if (t_q == TW'(BLANK_CYC - 1)) begin
                t_d     = '0;
                drive_d = 1'b1;
            end
        end else if (t_q == TW'(DWELL - 1)) begin
            t_d     = '0;
            drive_d = 1'b0;
            if (row_q == RW'(ROWS - 1)) begin
                row_d  = '0;
                wrap_d = 1'b1;
            end else begin
                row_d = row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            row_q   <= '0;
            t_q     <= '0;
            drive_q <= 1'b0;
        end else begin
            row_q   <= row_d;
            t_q     <= t_d;
            drive_q <= drive_d;
        end
    end

    assign o_row_idx    = row_q;
    assign o_row_nxt    = row_d;
    assign o_t_nxt      = t_d;
    assign o_drive_nxt  = drive_d;
    assign o_frame_wrap = wrap_d;

endmodule

// File: rtl/display_scan_pwm.sv
// Row-scan LED matrix driver with per-row PWM brightness, blanking between rows and
// frame-atomic capture of the bitmap and brightness.
module display_scan_pwm
    import display_pkg::*;
#(
    parameter int ROWS       = 16,
    parameter int COLS       = 16,
    parameter int DWELL      = 64,
    parameter int BLANK_CYC  = 2,
    parameter int BRIGHT_W   = 7,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_enable,
    input  logic [ROWS*COLS-1:0]     i_data,
    input  logic [BRIGHT_W-1:0]      i_bright,
    output logic [ROWS-1:0]          o_row_n,
    output logic [COLS-1:0]          o_col_n,
    output logic                     o_frame_start,
    output logic [clog2(ROWS)-1:0]   o_row_idx
);

    localparam int   RW  = clog2(ROWS);
    localparam int   TW  = clog2((DWELL > BLANK_CYC) ? DWELL : BLANK_CYC);
    localparam logic POL = inactive_level(ACTIVE_LOW);

    logic [1:0]           state_q, state_d;
    logic [ROWS*COLS-1:0] shadow_q, shadow_d;
    logic [BRIGHT_W-1:0]  bright_q, bright_d;
    logic                 frame_start_q, frame_start_d;
    logic [ROWS-1:0]      row_n_q, row_n_d;
    logic [COLS-1:0]      col_n_q, col_n_d;
    logic [ROWS-1:0]      row_act;
    logic [COLS-1:0]      col_act;

    logic                 run;
    logic [RW-1:0]        row_nxt;
    logic [TW-1:0]        t_nxt;
    logic                 drive_nxt;
    logic                 frame_wrap;

    assign run = i_enable && (state_q != ST_IDLE);

    display_scan_timer #(
        .ROWS      (ROWS),
        .DWELL     (DWELL),
        .BLANK_CYC (BLANK_CYC),
        .RW        (RW),
        .TW        (TW)
    ) u_timer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_run        (run),
        .o_row_idx    (o_row_idx),
        .o_row_nxt    (row_nxt),
        .o_t_nxt      (t_nxt),
        .o_drive_nxt  (drive_nxt),
        .o_frame_wrap (frame_wrap)
    );

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        bright_d      = bright_q;
        frame_start_d = 1'b0;
        if (!i_enable) begin
            state_d = ST_IDLE;
        end else begin
            if (state_q == ST_IDLE) begin
                state_d = ST_BLANK;
            end else begin
                state_d = drive_nxt ? ST_DRIVE : ST_BLANK;
            end
            // Capture only while staying enabled, so a disable on the wrap edge suppresses it.
            if ((state_q == ST_IDLE) || frame_wrap) begin
                shadow_d      = i_data;
                bright_d      = i_bright;
                frame_start_d = 1'b1;
            end
        end

        // Pins are computed from next-state values so they line up with the state register.
        row_act = '0;
        col_act = '0;
        if (state_d == ST_DRIVE) begin
            row_act[row_nxt] = 1'b1;
            if (int'(t_nxt) < int'(bright_d)) begin
                col_act = shadow_d[row_nxt*COLS +: COLS];
            end
        end
        row_n_d = row_act ^ {ROWS{POL}};
        col_n_d = col_act ^ {COLS{POL}};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            shadow_q      <= '0;
            bright_q      <= '0;
            frame_start_q <= 1'b0;
            row_n_q       <= {ROWS{POL}};
            col_n_q       <= {COLS{POL}};
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            bright_q      <= bright_d;
            frame_start_q <= frame_start_d;
            row_n_q       <= row_n_d;
            col_n_q       <= col_n_d;
        end
    end

    assign o_row_n       = row_n_q;
    assign o_col_n       = col_n_q;
    assign o_frame_start = frame_start_q;

endmodule
